// File: rtl/jtag_seq_packer.sv
`default_nettype none
// ============================================================================
// Module   : jtag_seq_packer
// Purpose  : Upstream stage of the JTAG controller. Parses the MCU byte
//            stream into 32-bit sequence entries and buffers them in a
//            first-word-fall-through FIFO that feeds the controller read port.
//            STORE headers are followed by raw data triplets that are passed
//            through as data entries and never decoded as headers.
// Ports    :
//   clk              system clock (posedge)
//   rst              asynchronous active-low reset
//   abort            synchronous clear of parser, FIFO and error flag
//   cmd_data/valid   host byte stream, accepted when cmd_valid && cmd_ready
//   cmd_ready        !full && !abort (held low while in reset)
//   out_seq_*        head entry of the FIFO (all zero while empty)
//   out_seq_re       pop the head entry
//   fifo_level       number of buffered entries
//   proto_err        sticky: undefined command code seen
// Revision : 1.0 - initial release
// ============================================================================
module jtag_seq_packer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  abort,
    input  logic [7:0]            cmd_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic                  out_seq_empty,
    output logic [4:0]            out_seq_command,
    output logic [2:0]            out_seq_bits,
    output logic [7:0]            out_seq_tms,
    output logic [7:0]            out_seq_tdi,
    output logic [7:0]            out_seq_read,
    input  logic                  out_seq_re,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  proto_err
);

    // Command codes shared with the controller.
    localparam logic [4:0] C_CMD_WR      = 5'h01;
    localparam logic [4:0] C_CMD_STORE   = 5'h02;
    localparam logic [4:0] C_CMD_EXECUTE = 5'h03;
    localparam logic [4:0] C_CMD_FLUSH   = 5'h04;

    localparam int               C_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL_LEVEL = (DEPTH_LOG2 + 1)'(C_DEPTH);

    typedef enum logic [3:0] {
        S_HDR  = 4'd0,
        S_TMS  = 4'd1,
        S_TDI  = 4'd2,
        S_RD   = 4'd3,
        S_LEN0 = 4'd4,
        S_LEN1 = 4'd5,
        S_DTMS = 4'd6,
        S_DTDI = 4'd7,
        S_DRD  = 4'd8
    } state_t;

    // ------------------------------------------------------------------
    // Parser state
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [2:0]  bits_q,  bits_d;
    logic [7:0]  tms_q,   tms_d;
    logic [7:0]  tdi_q,   tdi_d;
    logic [12:0] words_q, words_d;
    logic        perr_q,  perr_d;

    logic        w_accept;
    logic        w_push;
    logic [31:0] w_entry;
    logic [12:0] w_len;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;

    assign cmd_ready = rst & ~w_full & ~abort;
    assign w_accept  = cmd_valid & cmd_ready;

    // Payload triplet count: length in bits rounded up to whole bytes,
    // wraps silently at 13 bits.
    assign w_len = {cmd_data, tms_q[7:3]} + {12'd0, (tms_q[2:0] != 3'd0)};

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        words_d = words_q;
        perr_d  = perr_q;
        w_push  = 1'b0;
        w_entry = 32'd0;
        if (w_accept) begin
            case (state_q)
                S_HDR: begin
                    bits_d = cmd_data[2:0];
                    case (cmd_data[7:3])
                        C_CMD_WR:    state_d = S_TMS;
                        C_CMD_STORE: state_d = S_LEN0;
                        C_CMD_EXECUTE, C_CMD_FLUSH: begin
                            w_push  = 1'b1;
                            w_entry = {cmd_data, 24'd0};
                        end
                        default:     perr_d = 1'b1;
                    endcase
                end
                S_TMS: begin
                    tms_d   = cmd_data;
                    state_d = S_TDI;
                end
                S_TDI: begin
                    tdi_d   = cmd_data;
                    state_d = S_RD;
                end
                S_RD: begin
                    w_push  = 1'b1;
                    w_entry = {C_CMD_WR, bits_q, tms_q, tdi_q, cmd_data};
                    state_d = S_HDR;
                end
                S_LEN0: begin
                    tms_d   = cmd_data;
                    state_d = S_LEN1;
                end
                S_LEN1: begin
                    tdi_d   = cmd_data;
                    w_push  = 1'b1;
                    w_entry = {C_CMD_STORE, bits_q, tms_q, cmd_data, 8'h00};
                    words_d = w_len;
                    state_d = (w_len == 13'd0) ? S_HDR : S_DTMS;
                end
                S_DTMS: begin
                    tms_d   = cmd_data;
                    state_d = S_DTDI;
                end
                S_DTDI: begin
                    tdi_d   = cmd_data;
                    state_d = S_DRD;
                end
                S_DRD: begin
                    w_push  = 1'b1;
                    w_entry = {C_CMD_STORE, 3'd0, tms_q, tdi_q, cmd_data};
                    words_d = words_q - 13'd1;
                    state_d = (words_q == 13'd1) ? S_HDR : S_DTMS;
                end
                default: state_d = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HDR;
            bits_q  <= 3'd0;
            tms_q   <= 8'd0;
            tdi_q   <= 8'd0;
            words_q <= 13'd0;
            perr_q  <= 1'b0;
        end else if (abort) begin
            state_q <= S_HDR;
            bits_q  <= 3'd0;
            tms_q   <= 8'd0;
            tdi_q   <= 8'd0;
            words_q <= 13'd0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            words_q <= words_d;
            perr_q  <= perr_d;
        end
    end

    assign proto_err = perr_q;

    // ------------------------------------------------------------------
    // FWFT FIFO: the head is read combinationally from the array, so an
    // entry written at one edge is visible right after it.
    // ------------------------------------------------------------------
    logic [31:0]           mem_q [C_DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic [31:0]           w_head;

    assign w_full  = (level_q == C_FULL_LEVEL);
    assign w_empty = (level_q == '0);
    assign w_pop   = out_seq_re & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push && !abort) begin
            mem_q[wr_ptr_q] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign w_head          = w_empty ? 32'd0 : mem_q[rd_ptr_q];
    assign out_seq_empty   = w_empty;
    assign out_seq_command = w_head[31:27];
    assign out_seq_bits    = w_head[26:24];
    assign out_seq_tms     = w_head[23:16];
    assign out_seq_tdi     = w_head[15:8];
    assign out_seq_read    = w_head[7:0];
    assign fifo_level      = level_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_seq_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_seq_packer
// Purpose  : Self-checking bench for jtag_seq_packer. A byte table with
//            expected level / error flag per byte, followed by an ordered
//            drain against an expected entry table, plus directed sequences
//            for full/held-byte, pointer wrap, error and abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_seq_packer;

    localparam int C_DL2 = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         abort = 1'b0;
    logic [7:0]   cmd_data = 8'd0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         out_seq_empty;
    logic [4:0]   out_seq_command;
    logic [2:0]   out_seq_bits;
    logic [7:0]   out_seq_tms;
    logic [7:0]   out_seq_tdi;
    logic [7:0]   out_seq_read;
    logic         out_seq_re = 1'b0;
    logic [C_DL2:0] fifo_level;
    logic         proto_err;

    int checks   = 0;
    int failures = 0;

    jtag_seq_packer #(.DEPTH_LOG2(C_DL2)) dut (
        .clk             (clk),
        .rst             (rst),
        .abort           (abort),
        .cmd_data        (cmd_data),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .out_seq_empty   (out_seq_empty),
        .out_seq_command (out_seq_command),
        .out_seq_bits    (out_seq_bits),
        .out_seq_tms     (out_seq_tms),
        .out_seq_tdi     (out_seq_tdi),
        .out_seq_read    (out_seq_read),
        .out_seq_re      (out_seq_re),
        .fifo_level      (fifo_level),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic [4:0] lvl;
        logic       perr;
    } vec_t;

    vec_t        vecs [25];
    logic [31:0] exp_entries [12];

    function automatic logic [31:0] head();
        return {out_seq_command, out_seq_bits, out_seq_tms, out_seq_tdi, out_seq_read};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("send_timeout", 32'(cmd_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [31:0] exp);
        chk({name, "_empty"}, 32'(out_seq_empty), 32'd0);
        chk(name, head(), exp);
        @(negedge clk);
        out_seq_re = 1'b1;
        @(posedge clk);
        #1;
        out_seq_re = 1'b0;
    endtask

    initial begin
        // Byte table: codes WR=01, STORE=02, EXECUTE=03, FLUSH=04.
        vecs[0]  = '{8'h0D, 5'd0,  1'b0};  // WR bits=5
        vecs[1]  = '{8'hA5, 5'd0,  1'b0};
        vecs[2]  = '{8'h3C, 5'd0,  1'b0};
        vecs[3]  = '{8'h01, 5'd1,  1'b0};
        vecs[4]  = '{8'h10, 5'd1,  1'b0};  // STORE, len 0x0013 -> 3 words
        vecs[5]  = '{8'h13, 5'd1,  1'b0};
        vecs[6]  = '{8'h00, 5'd2,  1'b0};
        vecs[7]  = '{8'h18, 5'd2,  1'b0};  // looks like EXECUTE: data only
        vecs[8]  = '{8'h55, 5'd2,  1'b0};
        vecs[9]  = '{8'hFF, 5'd3,  1'b0};
        vecs[10] = '{8'h0D, 5'd3,  1'b0};
        vecs[11] = '{8'h10, 5'd3,  1'b0};
        vecs[12] = '{8'h00, 5'd4,  1'b0};
        vecs[13] = '{8'hF8, 5'd4,  1'b0};  // undefined code as data: no error
        vecs[14] = '{8'h01, 5'd4,  1'b0};
        vecs[15] = '{8'h02, 5'd5,  1'b0};
        vecs[16] = '{8'h18, 5'd6,  1'b0};  // EXECUTE
        vecs[17] = '{8'h20, 5'd7,  1'b0};  // FLUSH
        vecs[18] = '{8'h13, 5'd7,  1'b0};  // STORE bits=3, zero length
        vecs[19] = '{8'h00, 5'd7,  1'b0};
        vecs[20] = '{8'h00, 5'd8,  1'b0};
        vecs[21] = '{8'h1A, 5'd9,  1'b0};  // EXECUTE bits=2 parsed as header
        vecs[22] = '{8'h10, 5'd9,  1'b0};  // STORE, len 0x0008 -> 1 word
        vecs[23] = '{8'h08, 5'd9,  1'b0};
        vecs[24] = '{8'h00, 5'd10, 1'b0};

        exp_entries[0]  = 32'h0DA53C01;
        exp_entries[1]  = 32'h10130000;
        exp_entries[2]  = 32'h101855FF;
        exp_entries[3]  = 32'h100D1000;
        exp_entries[4]  = 32'h10F80102;
        exp_entries[5]  = 32'h18000000;
        exp_entries[6]  = 32'h20000000;
        exp_entries[7]  = 32'h13000000;
        exp_entries[8]  = 32'h1A000000;
        exp_entries[9]  = 32'h10080000;
        exp_entries[10] = 32'h10112233;
        exp_entries[11] = 32'h20000000;

        // Reset state.
        #22;
        chk("rst_ready",  32'(cmd_ready), 32'd0);
        chk("rst_empty",  32'(out_seq_empty), 32'd1);
        chk("rst_level",  32'(fifo_level), 32'd0);
        chk("rst_perr",   32'(proto_err), 32'd0);
        chk("rst_head",   head(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", 32'(cmd_ready), 32'd1);
        chk("idle_empty", 32'(out_seq_empty), 32'd1);
        chk("idle_level", 32'(fifo_level), 32'd0);
        chk("idle_perr",  32'(proto_err), 32'd0);

        // Table-driven parse.
        for (int i = 0; i < 25; i++) begin
            send_byte(vecs[i].b);
            chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d_perr", i), 32'(proto_err), 32'(vecs[i].perr));
            if (i == 3) begin
                chk("wr_head", head(), 32'h0DA53C01);
            end
        end
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h20);
        chk("tail_level", 32'(fifo_level), 32'd12);
        for (int i = 0; i < 12; i++) begin
            pop_check($sformatf("drain%0d", i), exp_entries[i]);
        end
        chk("drained_empty", 32'(out_seq_empty), 32'd1);
        chk("drained_head",  head(), 32'd0);
        // Pop while empty is ignored.
        @(negedge clk);
        out_seq_re = 1'b1;
        @(posedge clk);
        #1;
        out_seq_re = 1'b0;
        chk("pop_empty_level", 32'(fifo_level), 32'd0);

        // Full: 16 EXECUTE headers, the 17th byte is held.
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h18);
        end
        chk("full_level", 32'(fifo_level), 32'd16);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        cmd_data  = 8'h20;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("held_level", 32'(fifo_level), 32'd16);
        @(negedge clk);
        out_seq_re = 1'b1;
        @(posedge clk);
        #1;
        chk("pop_full_level", 32'(fifo_level), 32'd15);
        chk("pop_full_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        out_seq_re = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("held_accepted_level", 32'(fifo_level), 32'd16);
        for (int i = 0; i < 15; i++) begin
            pop_check($sformatf("full_drain%0d", i), 32'h18000000);
        end
        pop_check("full_drain_flush", 32'h20000000);
        chk("full_drained", 32'(fifo_level), 32'd0);

        // Wrap: 40 distinct WR entries in fill/drain rounds of 10.
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 10; j++) begin
                logic [7:0] k;
                k = 8'(r * 10 + j);
                send_byte({5'h01, k[2:0]});
                send_byte(k);
                send_byte(~k);
                send_byte(k + 8'd1);
            end
            chk($sformatf("wrap%0d_level", r), 32'(fifo_level), 32'd10);
            for (int j = 0; j < 10; j++) begin
                logic [7:0] k;
                k = 8'(r * 10 + j);
                pop_check($sformatf("wrap_entry%0d", r * 10 + j),
                          {5'h01, k[2:0], k, ~k, k + 8'd1});
            end
        end

        // Error and abort.
        send_byte(8'hF8);
        chk("err_perr",  32'(proto_err), 32'd1);
        chk("err_level", 32'(fifo_level), 32'd0);
        send_byte(8'h18);
        chk("err_sticky", 32'(proto_err), 32'd1);
        chk("pre_abort_level", 32'(fifo_level), 32'd1);
        send_byte(8'h0D);
        send_byte(8'hAA);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_level", 32'(fifo_level), 32'd0);
        chk("abort_perr",  32'(proto_err), 32'd0);
        chk("abort_empty", 32'(out_seq_empty), 32'd1);
        send_byte(8'h0D);
        send_byte(8'hA5);
        send_byte(8'h3C);
        chk("post_abort_partial", 32'(fifo_level), 32'd0);
        send_byte(8'h01);
        chk("post_abort_level", 32'(fifo_level), 32'd1);
        pop_check("post_abort_wr", 32'h0DA53C01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, limit 900000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/jtag_seq_packer.md
Name: jtag_seq_packer

Overview:
- Upstream stage of the JTAG controller.
- Accepts the byte stream from the MCU interface and parses it into JTAG sequence entries.
- Buffers the entries in a first-word-fall-through FIFO, which drives the controller's out_seq_* read port directly.
- Handles STORE payload framing, so the controller receives raw data entries after a STORE header.

Parameters:
- DEPTH_LOG2, 4, log2 of the FIFO entry count; default gives 16 entries of 32 bits each.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous clear of the parser and the FIFO.
- cmd_data  in  8  host byte.
- cmd_valid  in  1  cmd_data is valid.
- cmd_ready  out  1  byte accepted when cmd_valid && cmd_ready at posedge.
- out_seq_empty  out  1  FIFO empty.
- out_seq_command  out  5  head entry command code.
- out_seq_bits  out  3  head entry bit count.
- out_seq_tms  out  8  head entry TMS byte.
- out_seq_tdi  out  8  head entry TDI byte.
- out_seq_read  out  8  head entry read-mask byte.
- out_seq_re  in  1  pop the head entry.
- fifo_level  out  DEPTH_LOG2+1  current number of entries.
- proto_err  out  1  sticky flag: undefined command seen.

Behaviour:
- Reset (rst=0, asynchronous) state:
  - Parser in S_HDR; FIFO empty; out_seq_empty=1; fifo_level=0; proto_err=0; cmd_ready=0.
  - All out_seq_* data outputs are 0 while the FIFO is empty.
- abort=1 has the same effect as reset, applied on the next posedge. abort has priority over a simultaneous push or pop.
- cmd_ready is driven as !full && !abort. This is conservative: no byte is accepted while the FIFO is full, even one that would not complete an entry.
- Header byte: cmd = byte[7:3], bits = byte[2:0]. Command codes are taken from defines.v.
- Parser states:
  - S_HDR:
    - WR goes to S_TMS.
    - STORE goes to S_LEN0.
    - EXECUTE and FLUSH push an entry {cmd, bits, tms=0, tdi=0, read=0} immediately and stay in S_HDR.
    - Any other code sets proto_err, drops the byte and stays in S_HDR.
  - WR path: S_TMS, then S_TDI, then S_RD, which pushes {WR, bits, tms, tdi, rd} and returns to S_HDR.
  - S_LEN0: the byte is stored as tms; go to S_LEN1.
  - S_LEN1: the byte is stored as tdi.
    - Push {STORE, bits, tms, tdi, 0}.
    - Load words = {tdi, tms[7:3]} + (tms[2:0] != 0), 13 bits; the value is truncated on overflow.
    - If words == 0, go to S_HDR; otherwise go to S_DTMS.
  - Data loop: S_DTMS, then S_DTDI, then S_DRD.
    - S_DRD pushes {STORE, 0, tms, tdi, rd} and decrements words.
    - If words reaches 0, go to S_HDR; otherwise go back to S_DTMS.
    - Bytes in the data loop are never decoded as headers.
- FIFO:
  - Push latency: an entry pushed at edge N is visible on out_seq_* and out_seq_empty=0 after edge N.
  - Pop at posedge when out_seq_re && !empty; the next head appears the same edge.
  - out_seq_re while empty is ignored.
  - Simultaneous push and pop: level unchanged. At level 0 the pushed entry becomes the head.
  - Pointers wrap modulo 2^DEPTH_LOG2.
  - Full is asserted when level == 2^DEPTH_LOG2.
- proto_err is cleared only by rst or abort.
- Reset or abort mid-entry discards partially received bytes; no partial entry is ever pushed.

Test Plan:
- Reset/idle check: after rst release, out_seq_empty=1, cmd_ready=1, fifo_level=0, proto_err=0.
- WR entry: send {`FIFO_CMD_WR,3'd5}, 0xA5, 0x3C, 0x01 -> exactly one entry appears after the 4th byte with command=WR, bits=5, tms=0xA5, tdi=0x3C, read=0x01; fifo_level=1.
- STORE framing: send {`FIFO_CMD_STORE,0}, tms=0x13, tdi=0x00. words = 0x002+1 = 3, so 3 triplets follow. Then send EXECUTE and FLUSH headers.
  - Required result: 6 entries in order STORE, 3 data entries, EXECUTE, FLUSH.
  - A data triplet whose first byte equals a header code must not be decoded as a header.
- STORE with zero length: send {`FIFO_CMD_STORE,0}, tms=0x00, tdi=0x00 -> one entry pushed; the next byte is parsed as a header.
- FIFO full and wrap: hold out_seq_re=0 and push 16 EXECUTE headers.
  - Required: cmd_ready=0 at fifo_level=16; the 17th byte is held.
  - Then pulse out_seq_re once: cmd_ready=1 and the held byte is accepted.
  - Drain 40 entries through repeated fill/drain cycles; order is preserved across pointer wrap.
- Error and abort:
  - Send header cmd=5'h1F -> proto_err=1 and no entry is pushed.
  - Then send the WR header plus 1 byte, assert abort for one cycle -> fifo_level=0, proto_err=0, parser back in S_HDR; a full WR sequence then parses correctly.
